// File: rtl/xy_waypoint_sequencer.sv
// Waypoint sequencer: queues BCD X-Y targets and issues them one at a time to the
// XY motion controller, waiting for arrival and a fixed dwell between points.
module xy_waypoint_sequencer #(
   parameter int DEPTH        = 4,
   parameter int SETTLE       = 3,
   parameter int DWELL_CYCLES = 4,
   parameter int TIMEOUT      = 200
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wp_valid,
   input  logic [7:0]               wp_data,
   output logic                     wp_ready,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     at_target,
   output logic [7:0]               target_out,
   output logic                     motion,
   output logic                     busy,
   output logic                     done,
   output logic                     fault,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_MOVE  = 3'd2;
   localparam logic [2:0] S_DWELL = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;

   logic [2:0]    state;
   logic [2:0]    state_nx;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [7:0]    move_cnt;
   logic [7:0]    dwell_cnt;
   logic          push;
   logic          pop;
   logic          arrived;
   logic          timed_out;
   logic          dwell_end;
   logic          queue_empty;

   assign queue_empty = (fifo_count == CW'(0));
   assign wp_ready    = (fifo_count != CW'(DEPTH)) && (state != S_FAULT);
   // abort takes priority over any queue traffic in the same cycle
   assign push        = wp_valid && wp_ready && !abort;
   assign pop         = (state == S_ISSUE) && !abort;
   assign arrived     = at_target && (move_cnt >= 8'(SETTLE));
   assign timed_out   = (move_cnt == 8'(TIMEOUT - 1));
   assign dwell_end   = (dwell_cnt == 8'(DWELL_CYCLES - 1));

   assign motion = (state == S_MOVE);
   assign busy   = (state == S_ISSUE) || (state == S_MOVE) || (state == S_DWELL);
   assign done   = (state == S_DONE);
   assign fault  = (state == S_FAULT);

   // Next-state selection; arrival is checked before timeout so it wins a tie.
   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !queue_empty) state_nx = S_ISSUE;
               else                       state_nx = S_IDLE;
            end
            S_ISSUE: state_nx = S_MOVE;
            S_MOVE: begin
               if (arrived)        state_nx = S_DWELL;
               else if (timed_out) state_nx = S_FAULT;
               else                state_nx = S_MOVE;
            end
            S_DWELL: begin
               if (!dwell_end)       state_nx = S_DWELL;
               else if (queue_empty) state_nx = S_DONE;
               else                  state_nx = S_ISSUE;
            end
            S_DONE:  state_nx = S_IDLE;
            S_FAULT: state_nx = S_FAULT;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // State register and saturating move/dwell counters, cleared outside their state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         move_cnt  <= 8'd0;
         dwell_cnt <= 8'd0;
      end else begin
         state <= state_nx;
         if (state != S_MOVE)         move_cnt <= 8'd0;
         else if (move_cnt != 8'hFF)  move_cnt <= move_cnt + 8'd1;
         else                         move_cnt <= move_cnt;
         if (state != S_DWELL)        dwell_cnt <= 8'd0;
         else if (dwell_cnt != 8'hFF) dwell_cnt <= dwell_cnt + 8'd1;
         else                         dwell_cnt <= dwell_cnt;
      end
   end

   // Queue pointers, occupancy and the target register (kept across abort).
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= AW'(0);
         wr_ptr     <= AW'(0);
         fifo_count <= CW'(0);
         target_out <= 8'h00;
      end else if (abort) begin
         rd_ptr     <= AW'(0);
         wr_ptr     <= AW'(0);
         fifo_count <= CW'(0);
         target_out <= target_out;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         else      wr_ptr <= wr_ptr;
         if (pop) begin
            rd_ptr     <= rd_ptr + AW'(1);
            target_out <= mem[rd_ptr];
         end else begin
            rd_ptr     <= rd_ptr;
            target_out <= target_out;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Waypoint storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wp_data;
      else      mem[wr_ptr] <= mem[wr_ptr];
   end

endmodule
